// File: rtl/vdp99_pkg.sv
// vdp99_pkg: shared constants and types for the vdp99 host port.
// Holds port modes, status bit positions, control decode and FSM states.
package vdp99_pkg;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_CTRL = 1'b1;

    localparam int NUM_REGS = 8;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    // Second control byte, bits [7:6]; a register write only
    // needs bit 7 set, so CMD_REG is matched on its MSB alone.
    localparam logic [1:0] CMD_REG    = 2'b10;
    localparam logic [1:0] CMD_WSETUP = 2'b01;
    localparam logic [1:0] CMD_RSETUP = 2'b00;

    typedef enum logic {
        VRAM_IDLE = 1'b0,
        VRAM_BUSY = 1'b1
    } vram_state_t;

    // 14-bit VRAM address carried by a setup sequence.
    function automatic logic [13:0] setup_addr(
        input logic [7:0] lo,
        input logic [7:0] ctl
    );
        return {ctl[5:0], lo};
    endfunction

endpackage

// File: rtl/vdp99_status.sv
// vdp99_status: status register (F, 5S, C, num) and interrupt output.
// Ports: pxclk/reset, event pulses, rd_clr strobe, ie enable; status, irq out.
module vdp99_status
    import vdp99_pkg::*;
(
    input  logic       pxclk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       spr_5th,
    input  logic [4:0] spr_5th_num,
    input  logic       spr_coll,
    input  logic       rd_clr,
    input  logic       ie,
    output logic [7:0] status,
    output logic       irq
);

    logic       f_q;
    logic       s5_q;
    logic       c_q;
    logic [4:0] num_q;
    logic       irq_q;

    // A set event in the same cycle as a status read wins over the
    // clear, so the event is reported on the next read.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            f_q   <= 1'b0;
            s5_q  <= 1'b0;
            c_q   <= 1'b0;
            num_q <= 5'd0;
            irq_q <= 1'b0;
        end else begin
            if (frame_tick) begin
                f_q <= 1'b1;
            end else if (rd_clr) begin
                f_q <= 1'b0;
            end

            if (spr_coll) begin
                c_q <= 1'b1;
            end else if (rd_clr) begin
                c_q <= 1'b0;
            end

            // num freezes on the first fifth-sprite event until 5S clears.
            if (spr_5th && !s5_q) begin
                s5_q  <= 1'b1;
                num_q <= spr_5th_num;
            end else if (rd_clr) begin
                s5_q <= 1'b0;
            end

            irq_q <= f_q & ie;
        end
    end

    always_comb begin
        status        = 8'd0;
        status[ST_F]  = f_q;
        status[ST_5S] = s5_q;
        status[ST_C]  = c_q;
        status[4:0]   = num_q;
    end

    assign irq = irq_q;

endmodule

// File: rtl/vdp99_host_port.sv
// vdp99_host_port: CPU-side responder of the VDP: control/data ports,
// VDP registers, VRAM pointer, read-ahead buffer and status/irq.
// Ports: pxclk/reset; wr_tick/rd_tick/mode/din in, dout out (CPU side);
// vram_req/we/addr/wdata out, vram_ack/rdata in (arbiter side);
// regs out (R0..R7); frame_tick/spr_* event inputs; irq, overrun out.
// Build option: define VDP99_WR_RDBUF_EN to make data writes also
// load the read-ahead buffer with the written byte.
module vdp99_host_port
    import vdp99_pkg::*;
#(
    parameter  int VRAM_SIZE = 8 * 1024,
    localparam int AW        = $clog2(VRAM_SIZE)
) (
    input  logic          pxclk,
    input  logic          reset,
    input  logic          wr_tick,
    input  logic          rd_tick,
    input  logic          mode,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          vram_req,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_wdata,
    input  logic          vram_ack,
    input  logic [7:0]    vram_rdata,
    output logic [63:0]   regs,
    input  logic          frame_tick,
    input  logic          spr_5th,
    input  logic [4:0]    spr_5th_num,
    input  logic          spr_coll,
    output logic          irq,
    output logic          overrun
);

    vram_state_t state_q;
    vram_state_t state_d;

    logic [7:0]    latch_q;
    logic          second_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    rdbuf_q;
    logic [NUM_REGS*8-1:0] regs_q;
    logic          we_q;
    logic [AW-1:0] vaddr_q;
    logic [7:0]    wdata_q;
    logic          overrun_q;

    logic          ctrl_wr;
    logic          data_wr;
    logic          data_rd;
    logic          stat_rd;
    logic          ctrl_second;
    logic          is_reg;
    logic          is_wsetup;
    logic          is_rsetup;
    logic          issue;
    logic          accept;
    logic          drop;
    logic          rd_done;
    logic [13:0]   setup_full;
    logic [AW-1:0] setup_a;
    logic [AW-1:0] issue_addr;
    logic [7:0]    status;

    assign ctrl_wr = wr_tick && (mode == MODE_CTRL);
    assign data_wr = wr_tick && (mode == MODE_DATA);
    assign data_rd = rd_tick && (mode == MODE_DATA);
    assign stat_rd = rd_tick && (mode == MODE_CTRL);

    assign ctrl_second = ctrl_wr && second_q;

    assign setup_full = setup_addr(latch_q, din);
    assign setup_a    = setup_full[AW-1:0];

    always_comb begin
        is_reg    = 1'b0;
        is_wsetup = 1'b0;
        is_rsetup = 1'b0;
        if (ctrl_second) begin
            unique case (1'b1)
                din[7] == CMD_REG[1]:    is_reg    = 1'b1;
                din[7:6] == CMD_WSETUP:  is_wsetup = 1'b1;
                din[7:6] == CMD_RSETUP:  is_rsetup = 1'b1;
                default: ;
            endcase
        end
    end

    // A read setup fetches from the freshly loaded address, every other
    // access from the running pointer.
    assign issue      = is_rsetup || data_wr || data_rd;
    assign issue_addr = is_rsetup ? setup_a : addr_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            VRAM_IDLE: begin
                if (issue) begin
                    accept  = 1'b1;
                    state_d = VRAM_BUSY;
                end
            end
            VRAM_BUSY: begin
                if (vram_ack) begin
                    state_d = VRAM_IDLE;
                end
                drop = issue;
            end
            default: state_d = VRAM_IDLE;
        endcase
    end

    // Acks seen in IDLE (e.g. after a mid-access reset) never reach here.
    assign rd_done = (state_q == VRAM_BUSY) && vram_ack && !we_q;

    always_ff @(posedge pxclk) begin
        if (reset) begin
            state_q <= VRAM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            latch_q   <= 8'd0;
            second_q  <= 1'b0;
            addr_q    <= '0;
            rdbuf_q   <= 8'd0;
            regs_q    <= '0;
            we_q      <= 1'b0;
            vaddr_q   <= '0;
            wdata_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            if (ctrl_wr && !second_q) begin
                latch_q  <= din;
                second_q <= 1'b1;
            end else if (wr_tick || rd_tick) begin
                second_q <= 1'b0;
            end

            if (is_reg) begin
                regs_q[{din[2:0], 3'b000} +: 8] <= latch_q;
            end

            // Dropped accesses still advance the pointer.
            if (is_wsetup) begin
                addr_q <= setup_a;
            end else if (issue) begin
                addr_q <= issue_addr + AW'(1);
            end

            if (accept) begin
                we_q    <= data_wr;
                vaddr_q <= issue_addr;
                wdata_q <= din;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end

            if (rd_done) begin
                rdbuf_q <= vram_rdata;
            end
`ifdef VDP99_WR_RDBUF_EN
            if (data_wr) begin
                rdbuf_q <= din;
            end
`endif
        end
    end

    vdp99_status u_status (
        .pxclk       (pxclk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .spr_5th     (spr_5th),
        .spr_5th_num (spr_5th_num),
        .spr_coll    (spr_coll),
        .rd_clr      (stat_rd),
        .ie          (regs_q[13]),
        .status      (status),
        .irq         (irq)
    );

    assign dout       = (mode == MODE_CTRL) ? status : rdbuf_q;
    assign vram_req   = (state_q == VRAM_BUSY);
    assign vram_we    = we_q;
    assign vram_addr  = vaddr_q;
    assign vram_wdata = wdata_q;
    assign regs       = regs_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vdp99_host_port.sv
// tb_vdp99_host_port: directed bench for vdp99_host_port (VRAM_SIZE 16384)
// with a VRAM responder model and a queue of expected VRAM requests.
module tb_vdp99_host_port;

    localparam int VS = 16384;
    localparam int AW = 14;

    logic          pxclk = 1'b0;
    logic          reset;
    logic          wr_tick;
    logic          rd_tick;
    logic          mode;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          vram_req;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_wdata;
    logic          vram_ack;
    logic [7:0]    vram_rdata;
    logic [63:0]   regs;
    logic          frame_tick;
    logic          spr_5th;
    logic [4:0]    spr_5th_num;
    logic          spr_coll;
    logic          irq;
    logic          overrun;

    always #5 pxclk = ~pxclk;

    vdp99_host_port #(.VRAM_SIZE(VS)) dut (
        .pxclk       (pxclk),
        .reset       (reset),
        .wr_tick     (wr_tick),
        .rd_tick     (rd_tick),
        .mode        (mode),
        .din         (din),
        .dout        (dout),
        .vram_req    (vram_req),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_ack    (vram_ack),
        .vram_rdata  (vram_rdata),
        .regs        (regs),
        .frame_tick  (frame_tick),
        .spr_5th     (spr_5th),
        .spr_5th_num (spr_5th_num),
        .spr_coll    (spr_coll),
        .irq         (irq),
        .overrun     (overrun)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } req_t;

    req_t       exp_q[$];
    req_t       got_e;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] mem [VS];
    logic       ack_en;
    int         wcnt;
    logic [7:0] rd_val;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_req(input logic w, input logic [AW-1:0] a,
                              input logic [7:0] wd);
        exp_q.push_back(req_t'{we: w, addr: a, wdata: wd});
    endtask

    task automatic tick_wr(input logic m, input logic [7:0] d);
        repeat (8) @(negedge pxclk);
        mode    = m;
        din     = d;
        wr_tick = 1'b1;
        @(negedge pxclk);
        wr_tick = 1'b0;
    endtask

    task automatic tick_rd(input logic m, input logic fr,
                           output logic [7:0] d);
        repeat (8) @(negedge pxclk);
        mode       = m;
        rd_tick    = 1'b1;
        frame_tick = fr;
        #1 d = dout;
        @(negedge pxclk);
        rd_tick    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic pulse(input int which, input logic [4:0] n);
        @(negedge pxclk);
        spr_5th_num = n;
        case (which)
            0: frame_tick = 1'b1;
            1: spr_5th    = 1'b1;
            default: spr_coll = 1'b1;
        endcase
        @(negedge pxclk);
        frame_tick = 1'b0;
        spr_5th    = 1'b0;
        spr_coll   = 1'b0;
    endtask

    // VRAM responder: acks two cycles into a request, checks it
    // against the oldest expected request.
    initial begin
        vram_ack   = 1'b0;
        vram_rdata = 8'd0;
        wcnt       = 0;
        forever begin
            @(negedge pxclk);
            vram_ack = 1'b0;
            if (vram_req && ack_en && !reset) begin
                if (wcnt >= 1) begin
                    wcnt       = 0;
                    vram_ack   = 1'b1;
                    vram_rdata = mem[vram_addr];
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $error("FAIL vram_unexpected: got we=%0b addr=%0h expected none",
                               vram_we, vram_addr);
                    end else begin
                        got_e = exp_q.pop_front();
                        chk("vram_we", 64'(vram_we), 64'(got_e.we));
                        chk("vram_addr", 64'(vram_addr), 64'(got_e.addr));
                        if (got_e.we)
                            chk("vram_wdata", 64'(vram_wdata), 64'(got_e.wdata));
                    end
                    if (vram_we) mem[vram_addr] = vram_wdata;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < VS; i++) mem[i] = 8'd0;
        reset       = 1'b1;
        wr_tick     = 1'b0;
        rd_tick     = 1'b0;
        mode        = 1'b0;
        din         = 8'd0;
        frame_tick  = 1'b0;
        spr_5th     = 1'b0;
        spr_5th_num = 5'd0;
        spr_coll    = 1'b0;
        ack_en      = 1'b1;
        repeat (3) @(negedge pxclk);
        reset = 1'b0;

        mode = 1'b0;
        #1 chk("rst_dout_data", 64'(dout), 64'h0);
        mode = 1'b1;
        #1 chk("rst_dout_status", 64'(dout), 64'h0);
        chk("rst_regs", regs, 64'h0);
        chk("rst_vram_req", 64'(vram_req), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_overrun", 64'(overrun), 64'h0);

        // Register write R1 = 0x07
        tick_wr(1'b1, 8'h07);
        tick_wr(1'b1, 8'h81);
        chk("r1_write", regs, 64'h0700);
        repeat (2) @(negedge pxclk);
        chk("reg_no_req", 64'(vram_req), 64'h0);

        // Write setup 0x0000, two writes, then a read at 0x0002
        tick_wr(1'b1, 8'h00);
        tick_wr(1'b1, 8'h40);
        expect_req(1'b1, 14'h0000, 8'hAA);
        tick_wr(1'b0, 8'hAA);
        expect_req(1'b1, 14'h0001, 8'h55);
        tick_wr(1'b0, 8'h55);
        expect_req(1'b0, 14'h0002, 8'h00);
        tick_rd(1'b0, 1'b0, rd_val);

        // Read setup at 0x1234 and read-ahead
        mem[14'h1234] = 8'h5A;
        tick_wr(1'b1, 8'h34);
        expect_req(1'b0, 14'h1234, 8'h00);
        tick_wr(1'b1, 8'h12);
        expect_req(1'b0, 14'h1235, 8'h00);
        tick_rd(1'b0, 1'b0, rd_val);
        chk("rdbuf_ahead", 64'(rd_val), 64'h5A);

        // Address wrap 0x3FFF -> 0x0000
        tick_wr(1'b1, 8'hFF);
        tick_wr(1'b1, 8'h7F);
        expect_req(1'b1, 14'h3FFF, 8'h11);
        tick_wr(1'b0, 8'h11);
        expect_req(1'b1, 14'h0000, 8'h22);
        tick_wr(1'b0, 8'h22);

        // Frame interrupt and status read
        tick_wr(1'b1, 8'h20);
        tick_wr(1'b1, 8'h81);
        chk("r1_ie", regs, 64'h2000);
        chk("irq_idle", 64'(irq), 64'h0);
        pulse(0, 5'd0);
        repeat (2) @(negedge pxclk);
        chk("irq_set", 64'(irq), 64'h1);
        tick_rd(1'b1, 1'b0, rd_val);
        chk("status_f", 64'(rd_val), 64'h80);
        repeat (2) @(negedge pxclk);
        chk("irq_cleared", 64'(irq), 64'h0);
        pulse(0, 5'd0);
        repeat (2) @(negedge pxclk);
        chk("irq_set2", 64'(irq), 64'h1);
        tick_rd(1'b1, 1'b1, rd_val);
        chk("status_race_old", 64'(rd_val), 64'h80);
        repeat (2) @(negedge pxclk);
        chk("irq_race_kept", 64'(irq), 64'h1);
        tick_rd(1'b1, 1'b0, rd_val);
        chk("status_race_f_kept", 64'(rd_val), 64'h80);

        // Sprite status: first 5th-sprite number is held
        pulse(1, 5'd7);
        pulse(1, 5'd9);
        pulse(2, 5'd0);
        tick_rd(1'b1, 1'b0, rd_val);
        chk("status_spr", 64'(rd_val), 64'h67);
        tick_rd(1'b1, 1'b0, rd_val);
        chk("status_num_kept", 64'(rd_val), 64'h07);

        // Status read clears the half-written control sequence
        tick_wr(1'b1, 8'h12);
        tick_rd(1'b1, 1'b0, rd_val);
        chk("status_mid_seq", 64'(rd_val), 64'h07);
        tick_wr(1'b1, 8'h00);
        tick_wr(1'b1, 8'h40);
        expect_req(1'b1, 14'h0000, 8'h33);
        tick_wr(1'b0, 8'h33);

        // Overrun: second read while the first is outstanding
        repeat (8) @(negedge pxclk);
        ack_en = 1'b0;
        expect_req(1'b0, 14'h0001, 8'h00);
        tick_rd(1'b0, 1'b0, rd_val);
        chk("busy_req", 64'(vram_req), 64'h1);
        chk("no_overrun_yet", 64'(overrun), 64'h0);
        tick_rd(1'b0, 1'b0, rd_val);
        chk("overrun_set", 64'(overrun), 64'h1);
        chk("busy_req_held", 64'(vram_req), 64'h1);
        ack_en = 1'b1;
        repeat (6) @(negedge pxclk);
        chk("req_done", 64'(vram_req), 64'h0);

        // Reset while BUSY; pointer skipped 0x0002 on the dropped read
        ack_en = 1'b0;
        expect_req(1'b0, 14'h0003, 8'h00);
        tick_rd(1'b0, 1'b0, rd_val);
        chk("rdbuf_after_ack", 64'(rd_val), 64'h55);
        chk("busy_before_rst", 64'(vram_req), 64'h1);
        @(negedge pxclk);
        reset = 1'b1;
        @(negedge pxclk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        chk("rst_mid_req", 64'(vram_req), 64'h0);
        chk("rst_mid_overrun", 64'(overrun), 64'h0);
        chk("rst_mid_regs", regs, 64'h0);
        #1 chk("rst_mid_dout", 64'(dout), 64'h0);
        repeat (3) @(negedge pxclk);
        chk("rst_mid_req_stays", 64'(vram_req), 64'h0);
        ack_en = 1'b1;

        // Port works again from address 0 after reset
        expect_req(1'b1, 14'h0000, 8'h44);
        tick_wr(1'b0, 8'h44);
        tick_wr(1'b1, 8'h00);
        expect_req(1'b0, 14'h0000, 8'h00);
        tick_wr(1'b1, 8'h00);
        expect_req(1'b0, 14'h0001, 8'h00);
        tick_rd(1'b0, 1'b0, rd_val);
        chk("post_rst_read", 64'(rd_val), 64'h44);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++)
            @(negedge pxclk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
